// File: rtl/rev_alu_pkg.sv
// Shared opcode and state encodings for the bit-serial reversible ALU.
package rev_alu_pkg;

  typedef logic [1:0] state_t;

  localparam logic [2:0] OP_ADD    = 3'd0;
  localparam logic [2:0] OP_SUB    = 3'd1;
  localparam logic [2:0] OP_AND    = 3'd2;
  localparam logic [2:0] OP_OR     = 3'd3;
  localparam logic [2:0] OP_XOR    = 3'd4;
  localparam logic [2:0] OP_XNOR   = 3'd5;
  localparam logic [2:0] OP_PASS_A = 3'd6;
  localparam logic [2:0] OP_NOT_A  = 3'd7;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  function automatic logic is_arith(input logic [2:0] op_in);
    return (op_in[2:1] == 2'b00);
  endfunction

endpackage

// File: rtl/dpgGate.sv
// Double Peres gate; with d = 0 it is a reversible full adder (r = sum, s = carry).
module dpgGate (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic p,
  output logic q,
  output logic r,
  output logic s
);
  assign p = a;
  assign q = a ^ b;
  assign r = a ^ b ^ c;
  assign s = (((a ^ b) & c) ^ (a & b)) ^ d;
endmodule

// File: rtl/feyGate.sv
// Feynman (CNOT) gate: p = a, q = a ^ b.
module feyGate (
  input  logic a,
  input  logic b,
  output logic p,
  output logic q
);
  assign p = a;
  assign q = a ^ b;
endmodule

// File: rtl/fredGate.sv
// Fredkin (controlled swap) gate: a selects whether b and c are exchanged.
module fredGate (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic p,
  output logic q,
  output logic r
);
  assign p = a;
  assign q = (~a & b) | (a & c);
  assign r = (~a & c) | (a & b);
endmodule

// File: rtl/rev_alu_slice.sv
// One-bit ALU slice built only from reversible gates; output chosen by a Fredkin mux tree.
module rev_alu_slice
  import rev_alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [2:0] op,
  output logic       y,
  output logic       cout
);

  logic w_sum, w_and, w_or, w_xor, w_xnor, w_not_a;
  logic w_m0, w_m1, w_m2, w_m3, w_n0, w_n1;
  logic [19:0] w_g;

  dpgGate u_add (.a(a), .b(b), .c(cin), .d(1'b0),
                 .p(w_g[0]), .q(w_g[1]), .r(w_sum), .s(cout));
  tofGate u_and (.a(a), .b(b), .c(1'b0), .p(w_g[2]), .q(w_g[3]), .r(w_and));
  feyGate u_xor (.a(a), .b(b), .p(w_g[4]), .q(w_xor));
  // a ^ b ^ (a & b) is OR, reusing the XOR as the Toffoli target
  tofGate u_or (.a(a), .b(b), .c(w_xor), .p(w_g[5]), .q(w_g[6]), .r(w_or));
  feyGate u_xnor (.a(1'b1), .b(w_xor), .p(w_g[7]), .q(w_xnor));
  feyGate u_nota (.a(a), .b(1'b1), .p(w_g[8]), .q(w_not_a));

  fredGate u_m0 (.a(op[0]), .b(w_sum), .c(w_sum),   .p(w_g[9]),  .q(w_m0), .r(w_g[10]));
  fredGate u_m1 (.a(op[0]), .b(w_and), .c(w_or),    .p(w_g[11]), .q(w_m1), .r(w_g[12]));
  fredGate u_m2 (.a(op[0]), .b(w_xor), .c(w_xnor),  .p(w_g[13]), .q(w_m2), .r(w_g[14]));
  fredGate u_m3 (.a(op[0]), .b(a),     .c(w_not_a), .p(w_g[15]), .q(w_m3), .r(w_g[16]));
  fredGate u_n0 (.a(op[1]), .b(w_m0),  .c(w_m1),    .p(w_g[17]), .q(w_n0), .r(w_g[18]));
  fredGate u_n1 (.a(op[1]), .b(w_m2),  .c(w_m3),    .p(w_g[19]), .q(w_n1), .r());
  fredGate u_y  (.a(op[2]), .b(w_n0),  .c(w_n1),    .p(),        .q(y),    .r());

  logic w_unused;
  assign w_unused = ^w_g;

endmodule

// File: rtl/tofGate.sv
// Toffoli gate: r = c ^ (a & b), controls pass through.
module tofGate (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic p,
  output logic q,
  output logic r
);
  assign p = a;
  assign q = b;
  assign r = c ^ (a & b);
endmodule

// File: rtl/rev_alu_serial_ctrl.sv
// Bit-serial sequencer: steps the reversible slice LSB first and assembles result/flags.
module rev_alu_serial_ctrl
  import rev_alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             ovf,
  output logic             busy
);

  // state   | meaning
  // IDLE    | waiting for in_valid, operands latched on accept
  // RUN     | one operand bit per cycle through the slice
  // DONE    | result/flags presented until out_ready

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b, r_shift, r_result;
  logic [CNT_W-1:0] r_idx;
  logic             r_cy, r_carry, r_zero, r_ovf;

  logic             w_a_bit, w_b_bit, w_y, w_cout, w_last, w_arith;
  logic [WIDTH-1:0] w_res_nxt;

  assign w_arith   = is_arith(r_op);
  assign w_a_bit   = r_a[r_idx];
  assign w_b_bit   = r_b[r_idx] ^ (r_op == OP_SUB);
  assign w_last    = (r_idx == CNT_W'(WIDTH - 1));
  assign w_res_nxt = {w_y, r_shift[WIDTH-1:1]};

  rev_alu_slice u_slice (
    .a    (w_a_bit),
    .b    (w_b_bit),
    .cin  (r_cy),
    .op   (r_op),
    .y    (w_y),
    .cout (w_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)  w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == ST_IDLE);
    out_valid = (r_state == ST_DONE);
    busy      = (r_state != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op     <= OP_ADD;
      r_a      <= '0;
      r_b      <= '0;
      r_idx    <= '0;
      r_cy     <= 1'b0;
      r_shift  <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_op  <= op;
            r_a   <= a;
            r_b   <= b;
            r_idx <= '0;
            r_cy  <= (op == OP_SUB);
          end
        end
        ST_RUN: begin
          r_shift <= w_res_nxt;
          if (w_arith) r_cy <= w_cout;
          // r_cy is the carry into the MSB on the last step
          if (w_last) begin
            r_result <= w_res_nxt;
            r_zero   <= (w_res_nxt == '0);
            r_carry  <= w_arith & w_cout;
            r_ovf    <= w_arith & (r_cy ^ w_cout);
          end else begin
            r_idx <= r_idx + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;
  assign carry  = r_carry;
  assign zero   = r_zero;
  assign ovf    = r_ovf;

endmodule

// File: tb/tb_rev_alu_serial_ctrl.sv
// Directed bench for rev_alu_serial_ctrl with hand-computed expected values.
module tb_rev_alu_serial_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = 3'd0;
  logic [15:0] a = 16'h0, b = 16'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] result;
  logic        carry, zero, ovf, busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rev_alu_serial_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .zero(zero), .ovf(ovf), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs are raised just after edge T; out_valid must appear after edge T+17.
  task automatic run_txn(input string tag, input logic [2:0] t_op, input logic [15:0] t_a,
                         input logic [15:0] t_b, input logic [15:0] e_res, input logic e_c,
                         input logic e_z, input logic e_v);
    int cyc;
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    op = t_op; a = t_a; b = t_b; in_valid = 1'b1;
    cyc = 0;
    do begin
      tick();
      in_valid = 1'b0;
      cyc++;
    end while (!out_valid && cyc < 40);
    chk({tag, "_latency"}, cyc, 32'd17);
    chk({tag, "_result"}, {16'd0, result}, {16'd0, e_res});
    chk({tag, "_flags"}, {29'd0, carry, zero, ovf}, {29'd0, e_c, e_z, e_v});
  endtask

  logic [2:0]  lop [6] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [15:0] lexp[6] = '{16'h3030, 16'hFCFC, 16'hCCCC, 16'h3333, 16'hF0F0, 16'h0F0F};

  logic [2:0]  bop [3] = '{3'd0, 3'd1, 3'd2};
  logic [15:0] ba  [3] = '{16'h0001, 16'h0010, 16'hFFFF};
  logic [15:0] bb  [3] = '{16'h0002, 16'h0001, 16'h00FF};
  logic [15:0] bres[3] = '{16'h0003, 16'h000F, 16'h00FF};
  logic        bcy [3] = '{1'b0, 1'b1, 1'b0};

  initial begin
    int k, n_acc, n_out;
    int acc_cyc[4];
    logic prev_ready;

    // Reset and reset state
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid_busy", {30'd0, out_valid, busy}, 32'd0);
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_flags", {29'd0, carry, zero, ovf}, 32'd0);

    // Arithmetic boundaries
    run_txn("add_ovf", 3'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1);
    tick();
    run_txn("sub_zero", 3'd1, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b1, 1'b0);
    tick();
    run_txn("sub_borrow", 3'd1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    tick();

    // Logic ops on F0F0 / 3C3C
    for (int i = 0; i < 6; i++) begin
      run_txn($sformatf("logic%0d", i), lop[i], 16'hF0F0, 16'h3C3C, lexp[i], 1'b0, 1'b0, 1'b0);
      tick();
    end

    // Backpressure with ignored input pulses
    out_ready = 1'b0;
    run_txn("bp", 3'd4, 16'hF0F0, 16'h3C3C, 16'hCCCC, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      op = 3'd0; a = 16'h1111 * 16'(i + 1); b = 16'h0101;
      tick();
      chk($sformatf("bp_hold%0d_ctl", i), {30'd0, out_valid, in_ready}, 32'd2);
      chk($sformatf("bp_hold%0d_res", i), {13'd0, carry, zero, ovf, result}, {16'd0, 16'hCCCC});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_ctl", {30'd0, out_valid, in_ready}, 32'd1);
    chk("bp_release_res", {16'd0, result}, {16'd0, 16'hCCCC});
    tick();

    // Reset after bit 7 of a RUN: accept at T+1, bit 7 processed at T+9
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    op = 3'd0; a = 16'h1234; b = 16'h1111; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_ctl", {29'd0, in_ready, out_valid, busy}, 32'd4);
    chk("mid_rst_result", {16'd0, result}, 32'd0);
    tick();
    chk("mid_rst_no_valid", {31'd0, out_valid}, 32'd0);
    run_txn("post_rst_add", 3'd0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0);
    tick();

    // Back-to-back with in_valid held high
    k = 0; n_acc = 0; n_out = 0;
    op = bop[0]; a = ba[0]; b = bb[0]; in_valid = 1'b1;
    prev_ready = in_ready;
    for (int cyc = 1; cyc <= 70; cyc++) begin
      tick();
      if (prev_ready && k < 3) begin
        if (n_acc < 4) acc_cyc[n_acc] = cyc;
        n_acc++;
        k++;
        if (k < 3) begin
          op = bop[k]; a = ba[k]; b = bb[k];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        if (n_out < 3) begin
          chk($sformatf("b2b_res%0d", n_out), {16'd0, result}, {16'd0, bres[n_out]});
          chk($sformatf("b2b_cy%0d", n_out), {31'd0, carry}, {31'd0, bcy[n_out]});
        end
        n_out++;
      end
      prev_ready = in_ready;
    end
    chk("b2b_accepts", n_acc, 32'd3);
    chk("b2b_outputs", n_out, 32'd3);
    chk("b2b_ii01", acc_cyc[1] - acc_cyc[0], 32'd18);
    chk("b2b_ii12", acc_cyc[2] - acc_cyc[1], 32'd18);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
